// File: rtl/seq_counter_gen.sv
// seq_counter_gen: bounded up/down sequence counter with run/idle FSM and a registered done pulse.
// Wrap statistics are built only when SEQ_CNT_WRAP_STATS_EN is defined.
module seq_counter_gen #(
  parameter int WIDTH   = 2,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = (1 << WIDTH) - 1,
  parameter int WRAP_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              start,
  input  logic              stop,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              dir,
  input  logic              mode,
  output logic [WIDTH-1:0]  q_out,
  output logic              done,
  output logic              busy,
  output logic [WRAP_W-1:0] wrap_cnt
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [WIDTH-1:0] LO = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] HI = WIDTH'(MAX_VAL);
  state_t state, state_nx;
  logic [WIDTH-1:0] q_nx, term, init, clamped, stepped;
  logic done_nx;
  assign term    = dir ? HI : LO;
  assign init    = dir ? LO : HI;
  assign clamped = (int'(load_val) < MIN_VAL) ? LO : (int'(load_val) > MAX_VAL) ? HI : load_val;
  // q_out always lies in range, so a step either moves one toward term or wraps from it
  assign stepped = (q_out == term) ? init : dir ? q_out + 1'b1 : q_out - 1'b1;
  assign busy    = state == RUN;
  always_comb begin
    state_nx = state;
    q_nx     = q_out;
    done_nx  = 1'b0;
    if (state == IDLE && start && !stop) begin
      state_nx = RUN;
      q_nx     = init;
    end else if (state == RUN && stop) begin
      state_nx = IDLE;
    end else if (state == RUN && en && !load) begin
      q_nx     = stepped;
      done_nx  = (q_out != term) && (stepped == term);
      state_nx = (done_nx && mode) ? IDLE : RUN;
    end
    if (load) q_nx = clamped;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      q_out <= LO;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      q_out <= q_nx;
      done  <= done_nx;
    end
  end
`ifdef SEQ_CNT_WRAP_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wrap_cnt <= '0;
    else if (done_nx && ~&wrap_cnt) wrap_cnt <= wrap_cnt + 1'b1;
  end
`else
  assign wrap_cnt = '0;
`endif
endmodule

// File: doc/seq_counter_gen.md
# seq_counter_gen

Parametrised sequence counter with registered terminal-count `done` pulse, up/down direction, synchronous load, start/stop control and free-run or one-shot modes. It generalises the team's fixed 2-bit `seq_logic` counter: configurable width and count range, a controlled run/idle state machine, and optional wrap statistics. It sits in sequencing datapaths where a block must step through a bounded count and flag completion to an event-driven consumer.

## Interface
- `WIDTH`, 2: counter width in bits.
- `MIN_VAL`, 0: lowest count value.
- `MAX_VAL`, (1<<WIDTH)-1: highest count value. Legal range: MIN_VAL < MAX_VAL ≤ 2^WIDTH-1.
- `WRAP_W`, 8: width of wrap statistics counter.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable; one step per cycle while in RUN.
- `start`  in  1  IDLE→RUN request.
- `stop`  in  1  RUN→IDLE request.
- `load`  in  1  synchronous load of `load_val`.
- `load_val`  in  WIDTH  value for `load`.
- `dir`  in  1  1 = count up, 0 = count down.
- `mode`  in  1  0 = free-run (wrap), 1 = one-shot.
- `q_out`  out  WIDTH  current count.
- `done`  out  1  one-cycle terminal-count pulse.
- `busy`  out  1  high while FSM is in RUN.
- `wrap_cnt`  out  WRAP_W  number of `done` pulses (see Configuration).

## Operation
- Reset values: `q_out`=MIN_VAL, `done`=0, `busy`=0, `wrap_cnt`=0, FSM in IDLE.
- Terminal value T = MAX_VAL when `dir`=1, MIN_VAL when `dir`=0. Start value S = MIN_VAL when `dir`=1, MAX_VAL when `dir`=0.
- FSM states: IDLE, RUN.
  - IDLE, `start`=1 → RUN; `q_out`<=S (unless `load` is also high).
  - RUN, `stop`=1 → IDLE; `q_out` holds. `stop` has priority over counting and over `start`.
  - RUN, one-shot mode, step lands on T → IDLE on the same edge.
  - `start` in RUN and `stop` in IDLE are ignored.
- Step in RUN with `en`=1: `q_out` ± 1 toward T. At T in free-run, the next step wraps to S. The wrap is not a done event.
- `done`=1 for exactly one cycle when a counting step makes `q_out` equal T. It is never asserted by load, start or reset. If `en` is held low at T, `done` still drops after one cycle.
- `load` has priority over a step in any state. `q_out`<=`load_val` clamped to [MIN_VAL, MAX_VAL]. FSM state is unchanged (except combined with `start` in IDLE). No `done`, even if `load_val`=T.
- A `dir` change in RUN takes effect on the next step. If `q_out` is already beyond the new T, counting continues toward it without overshoot, because the range is clamped.
- `mode` is sampled every step; changing it mid-run is legal.

## Timing
- All outputs registered; no combinational input→output paths.
- `start` at edge k: `busy`=1 and `q_out`=S after edge k; first step at edge k+1 if `en`.
- `done` is coincident with the cycle `q_out` first shows T.
- One-shot: `busy` falls on the same edge `done` rises.
- Asynchronous reset mid-count: all outputs go to reset values immediately, with no `done` pulse. Counting resumes only after `reset_n` is released and a new `start` arrives.

## Configuration
- `SEQ_CNT_WRAP_STATS_EN` defined:
  - `wrap_cnt` increments on every `done` pulse.
  - Saturates at 2^WRAP_W-1.
  - Cleared only by reset.
- Not defined:
  - `wrap_cnt` tied to 0.
  - No statistics logic is synthesised.
  - The port remains present.

## Test plan
- WIDTH=2 defaults, free-run up, `en`=1 after `start` → `q_out` 0,1,2,3,0,1…; `done`=1 only in the cycles `q_out`=3; `busy` stays 1.
- One-shot down, MIN_VAL=2, MAX_VAL=9, WIDTH=4 → `q_out` 9..2; `done` and `busy`↓ on the same edge at 2; a further `start` reloads 9.
- `load`=1, `load_val`=3 in RUN with MAX_VAL=3 → `q_out`=3 and no `done`; the next step wraps to 0.
- `load_val`=12 with WIDTH=4, MAX_VAL=9 → `q_out`=9 (clamped).
- Async reset asserted at `q_out`=2 mid-run → `q_out`=0, `busy`=0, `done`=0 immediately; `start`+`stop` in the same IDLE cycle → remains IDLE.
- With `SEQ_CNT_WRAP_STATS_EN` and WRAP_W=2, run 5 wraps → `wrap_cnt`=3 (saturated); without the macro → `wrap_cnt`=0 throughout.
